// File: rtl/zs_mtimer.sv
// RISC-V machine timer: 64-bit mtime with a programmable prescaler, 64-bit mtimecmp,
// a level interrupt and a single-cycle register bus with a registered response.
module zs_mtimer #(
  parameter int unsigned AddrW     = 5,
  parameter int unsigned PrescaleW = 12,
  parameter logic [63:0] CmpRst    = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             reg_req_i,
  input  logic             reg_we_i,
  input  logic [AddrW-1:0] reg_addr_i,
  input  logic [31:0]      reg_wdata_i,
  input  logic [3:0]       reg_be_i,
  output logic             reg_rvalid_o,
  output logic [31:0]      reg_rdata_o,
  output logic             reg_err_o,
  output logic             irq_timer_o
);

  logic [63:0]          mtime_reg, mtime_next;
  logic [63:0]          cmp_reg, cmp_next;
  logic [31:0]          shadow_reg, shadow_next;
  logic                 en_reg, en_next;
  logic                 irq_en_reg, irq_en_next;
  logic [PrescaleW-1:0] prescale_reg, prescale_next;
  logic [PrescaleW-1:0] presc_cnt_reg, presc_cnt_next;
  logic                 rvalid_reg, err_reg, irq_reg;
  logic [31:0]          rdata_reg, rdata_next;
  logic                 tick, mapped;
  logic [31:0]          rd_val;
  logic [31:0]          be_mask;
  logic [5:0]           wr_sel;
  logic [2:0]           reg_idx;
  logic                 unused_addr_bits;

  assign reg_idx          = reg_addr_i[4:2];
  assign unused_addr_bits = ^reg_addr_i[1:0];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign be_mask[8*gi +: 8] = {8{reg_be_i[gi]}};
    end
    for (gi = 0; gi < 6; gi++) begin : g_wsel
      assign wr_sel[gi] = reg_req_i && reg_we_i && (reg_idx == 3'(gi));
    end
  endgenerate

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [31:0] mask);
    return (old_val & ~mask) | (new_val & mask);
  endfunction

  assign tick = en_reg && (presc_cnt_reg == prescale_reg);

  always_comb begin
    mtime_next     = mtime_reg;
    cmp_next       = cmp_reg;
    en_next        = en_reg;
    irq_en_next    = irq_en_reg;
    prescale_next  = prescale_reg;
    presc_cnt_next = presc_cnt_reg;
    shadow_next    = shadow_reg;

    // A write to either half of mtime wins over the tick for the whole counter.
    if (wr_sel[0]) begin
      mtime_next[31:0] = merge_lanes(mtime_reg[31:0], reg_wdata_i, be_mask);
    end else if (wr_sel[1]) begin
      mtime_next[63:32] = merge_lanes(mtime_reg[63:32], reg_wdata_i, be_mask);
    end else if (tick) begin
      mtime_next = mtime_reg + 64'd1;
    end

    if (wr_sel[2]) cmp_next[31:0]  = merge_lanes(cmp_reg[31:0], reg_wdata_i, be_mask);
    if (wr_sel[3]) cmp_next[63:32] = merge_lanes(cmp_reg[63:32], reg_wdata_i, be_mask);

    if (wr_sel[4] && reg_be_i[0]) begin
      en_next     = reg_wdata_i[0];
      irq_en_next = reg_wdata_i[1];
    end
    if (wr_sel[5]) begin
      prescale_next = (prescale_reg & ~be_mask[PrescaleW-1:0]) |
                      (reg_wdata_i[PrescaleW-1:0] & be_mask[PrescaleW-1:0]);
    end

    if (wr_sel[4] || wr_sel[5]) begin
      presc_cnt_next = '0;
    end else if (en_reg) begin
      presc_cnt_next = tick ? '0 : presc_cnt_reg + 1'b1;
    end

    // Snapshot the upper half so a following MTIME_HI read is coherent with this LO read.
    if (reg_req_i && !reg_we_i && reg_idx == 3'd0) shadow_next = mtime_reg[63:32];
  end

  always_comb begin
    rd_val = '0;
    mapped = 1'b1;
    case (reg_idx)
      3'd0:    rd_val = mtime_reg[31:0];
      3'd1:    rd_val = shadow_reg;
      3'd2:    rd_val = cmp_reg[31:0];
      3'd3:    rd_val = cmp_reg[63:32];
      3'd4:    rd_val = {30'd0, irq_en_reg, en_reg};
      3'd5:    rd_val = 32'(prescale_reg);
      default: mapped = 1'b0;
    endcase
    rdata_next = (reg_req_i && !reg_we_i && mapped) ? rd_val : '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mtime_reg     <= '0;
      cmp_reg       <= CmpRst;
      shadow_reg    <= '0;
      en_reg        <= 1'b0;
      irq_en_reg    <= 1'b0;
      prescale_reg  <= '0;
      presc_cnt_reg <= '0;
      rvalid_reg    <= 1'b0;
      rdata_reg     <= '0;
      err_reg       <= 1'b0;
      irq_reg       <= 1'b0;
    end else begin
      mtime_reg     <= mtime_next;
      cmp_reg       <= cmp_next;
      shadow_reg    <= shadow_next;
      en_reg        <= en_next;
      irq_en_reg    <= irq_en_next;
      prescale_reg  <= prescale_next;
      presc_cnt_reg <= presc_cnt_next;
      rvalid_reg    <= reg_req_i;
      rdata_reg     <= rdata_next;
      err_reg       <= reg_req_i && !mapped;
      irq_reg       <= irq_en_reg && (mtime_reg >= cmp_reg);
    end
  end

  assign reg_rvalid_o = rvalid_reg;
  assign reg_rdata_o  = rdata_reg;
  assign reg_err_o    = err_reg;
  assign irq_timer_o  = irq_reg;

endmodule

// File: tb/tb_zs_mtimer.sv
// Scoreboard bench for zs_mtimer: each bus transaction pushes its expected response,
// and each test drains the queue against the responses captured one cycle later.
module tb_zs_mtimer;

  localparam logic [4:0] A_MLO  = 5'h00;
  localparam logic [4:0] A_MHI  = 5'h04;
  localparam logic [4:0] A_CLO  = 5'h08;
  localparam logic [4:0] A_CHI  = 5'h0C;
  localparam logic [4:0] A_CTRL = 5'h10;
  localparam logic [4:0] A_PRE  = 5'h14;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  be = '0;
  logic        reg_rvalid_o;
  logic [31:0] reg_rdata_o;
  logic        reg_err_o;
  logic        irq_timer_o;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t obs_q[$];

  zs_mtimer dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .reg_req_i   (req),
    .reg_we_i    (we),
    .reg_addr_i  (addr),
    .reg_wdata_i (wdata),
    .reg_be_i    (be),
    .reg_rvalid_o(reg_rvalid_o),
    .reg_rdata_o (reg_rdata_o),
    .reg_err_o   (reg_err_o),
    .irq_timer_o (irq_timer_o)
  );

  always #5 clk = ~clk;

  // One-cycle request; the response is captured 1 time unit after the edge that samples it.
  task automatic bus(input logic w, input logic [4:0] a, input logic [31:0] d,
                     input logic [3:0] b, input logic [31:0] exp_rdata, input logic exp_err);
    rsp_t o;
    exp_q.push_back({1'b1, exp_rdata, exp_err});
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0;
    o.rvalid = reg_rvalid_o; o.rdata = reg_rdata_o; o.err = reg_err_o;
    obs_q.push_back(o);
    $display("txn %s addr=0x%02h wdata=0x%08h be=%b -> rvalid=%b rdata=0x%08h err=%b",
             w ? "WR" : "RD", a, d, b, o.rvalid, o.rdata, o.err);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus(1'b1, a, d, 4'hF, 32'h0, 1'b0);
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp_rdata);
    bus(1'b0, a, 32'h0, 4'h0, exp_rdata, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rsp_t e, o;
    #3;
    checks++;
    if ({reg_rvalid_o, reg_rdata_o, reg_err_o, irq_timer_o} !== 35'd0) begin
      failures++;
      $display("FAIL reset_outputs got rvalid=%b rdata=%h err=%b irq=%b want all 0",
               reg_rvalid_o, reg_rdata_o, reg_err_o, irq_timer_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    wr(A_CHI, 32'h0);
    wr(A_CLO, 32'h0);
    wr(A_CTRL, 32'h3);
    idle(2);
    checks++;
    if (irq_timer_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_pre_irq got %b want 1", irq_timer_o);
    end
    rd(A_CTRL, 32'h3);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL reset_setup got rv=%b rd=%h err=%b want rv=%b rd=%h err=%b",
                 o.rvalid, o.rdata, o.err, e.rvalid, e.rdata, e.err);
      end
    end
    // Assert reset away from the clock edge while the read response is still on the bus.
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({reg_rvalid_o, reg_rdata_o, reg_err_o, irq_timer_o} !== 35'd0) begin
      failures++;
      $display("FAIL reset_async got rvalid=%b rdata=%h err=%b irq=%b want all 0",
               reg_rvalid_o, reg_rdata_o, reg_err_o, irq_timer_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    rd(A_MLO, 32'h0);
    rd(A_CHI, 32'hFFFF_FFFF);
    rd(A_CLO, 32'hFFFF_FFFF);
    rd(A_CTRL, 32'h0);
    rd(A_PRE, 32'h0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL reset_values got rv=%b rd=%h err=%b want rv=%b rd=%h err=%b",
                 o.rvalid, o.rdata, o.err, e.rvalid, e.rdata, e.err);
      end
    end
  endtask

  task automatic test_prescale;
    rsp_t e, o;
    wr(A_PRE, 32'd3);
    wr(A_CTRL, 32'h1);
    idle(39);
    rd(A_MLO, 32'd9);
    wr(A_CTRL, 32'h0);
    wr(A_MLO, 32'h0);
    wr(A_MHI, 32'h0);
    wr(A_PRE, 32'h0);
    wr(A_CTRL, 32'h1);
    for (int i = 0; i < 6; i++) rd(A_MLO, 32'(i));
    wr(A_CTRL, 32'h0);
    idle(5);
    rd(A_MLO, 32'd7);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL prescale got rv=%b rd=%h err=%b want rv=%b rd=%h err=%b",
                 o.rvalid, o.rdata, o.err, e.rvalid, e.rdata, e.err);
      end
    end
  endtask

  task automatic test_carry;
    rsp_t e, o;
    wr(A_CTRL, 32'h0);
    wr(A_MLO, 32'hFFFF_FFFE);
    wr(A_MHI, 32'h0);
    wr(A_CTRL, 32'h1);
    rd(A_MLO, 32'hFFFF_FFFE);
    rd(A_MHI, 32'h0);
    rd(A_MLO, 32'h0);
    rd(A_MHI, 32'h1);
    wr(A_CTRL, 32'h0);
    rd(A_MHI, 32'h1);
    rd(A_MLO, 32'h3);
    rd(A_MHI, 32'h1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL carry_snapshot got rv=%b rd=%h err=%b want rv=%b rd=%h err=%b",
                 o.rvalid, o.rdata, o.err, e.rvalid, e.rdata, e.err);
      end
    end
  endtask

  task automatic test_irq;
    rsp_t e, o;
    int rise;
    rise = -1;
    wr(A_CTRL, 32'h0);
    wr(A_MLO, 32'h0);
    wr(A_MHI, 32'h0);
    wr(A_CHI, 32'h0);
    wr(A_CLO, 32'd20);
    wr(A_CTRL, 32'h3);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (irq_timer_o === 1'b1 && rise < 0) rise = k;
    end
    checks++;
    if (rise != 21) begin
      failures++;
      $display("FAIL irq_rise got cycle %0d want 21", rise);
    end
    wr(A_CLO, 32'd100);
    checks++;
    if (irq_timer_o !== 1'b1) begin
      failures++;
      $display("FAIL irq_hold_after_write got %b want 1", irq_timer_o);
    end
    idle(1);
    checks++;
    if (irq_timer_o !== 1'b0) begin
      failures++;
      $display("FAIL irq_fall got %b want 0", irq_timer_o);
    end
    wr(A_CTRL, 32'h1);
    idle(70);
    checks++;
    if (irq_timer_o !== 1'b0) begin
      failures++;
      $display("FAIL irq_masked got %b want 0", irq_timer_o);
    end
    wr(A_CTRL, 32'h3);
    idle(1);
    checks++;
    if (irq_timer_o !== 1'b1) begin
      failures++;
      $display("FAIL irq_unmask got %b want 1", irq_timer_o);
    end
    wr(A_CTRL, 32'h0);
    wr(A_CLO, 32'hFFFF_FFFF);
    wr(A_CHI, 32'hFFFF_FFFF);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL irq_bus got rv=%b rd=%h err=%b want rv=%b rd=%h err=%b",
                 o.rvalid, o.rdata, o.err, e.rvalid, e.rdata, e.err);
      end
    end
  endtask

  task automatic test_bus;
    rsp_t e, o;
    wr(A_CLO, 32'h1122_3344);
    bus(1'b1, A_CLO, 32'hAABB_CCDD, 4'b0010, 32'h0, 1'b0);
    rd(A_CLO, 32'h1122_CC44);
    bus(1'b0, 5'h18, 32'h0, 4'h0, 32'h0, 1'b1);
    bus(1'b1, 5'h1C, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1);
    wr(A_PRE, 32'hFFFF_FFFF);
    rd(A_PRE, 32'h0000_0FFF);
    bus(1'b1, A_PRE, 32'h1234_56A5, 4'b0001, 32'h0, 1'b0);
    rd(A_PRE, 32'h0000_0FA5);
    wr(A_PRE, 32'h0);
    wr(A_CTRL, 32'hFFFF_FFFF);
    rd(A_CTRL, 32'h3);
    wr(A_CTRL, 32'h0);
    rd(A_CHI, 32'hFFFF_FFFF);
    wr(A_CHI, 32'h1234_5678);
    rd(A_CHI, 32'h1234_5678);
    idle(1);
    checks++;
    if (reg_rvalid_o !== 1'b0) begin
      failures++;
      $display("FAIL bus_rvalid_idle got %b want 0", reg_rvalid_o);
    end
    wr(A_CHI, 32'hFFFF_FFFF);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL bus got rv=%b rd=%h err=%b want rv=%b rd=%h err=%b",
                 o.rvalid, o.rdata, o.err, e.rvalid, e.rdata, e.err);
      end
    end
  endtask

  task automatic test_collision;
    rsp_t e, o;
    wr(A_CTRL, 32'h0);
    wr(A_MHI, 32'h0);
    wr(A_MLO, 32'h0);
    wr(A_PRE, 32'h1);
    wr(A_CTRL, 32'h1);
    idle(1);
    wr(A_MLO, 32'd5);
    rd(A_MLO, 32'd5);
    rd(A_MLO, 32'd5);
    rd(A_MLO, 32'd6);
    wr(A_CTRL, 32'h0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL collision got rv=%b rd=%h err=%b want rv=%b rd=%h err=%b",
                 o.rvalid, o.rdata, o.err, e.rvalid, e.rdata, e.err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_prescale();
    test_carry();
    test_irq();
    test_bus();
    test_collision();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
